uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmitter between N byte sources (switch FIFO, RX-echo FIFO, status

---
 rtl/uart_tx_arbiter_pkg.sv | 20 ++
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter_rr_picker.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 150 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Covers the FSM state encoding, the byte width and the index-width helper.
package uart_tx_arbiter_pkg;

  localparam int unsigned ByteW = 8;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWaitBusy,
    StWaitDone,
    StHold
  } arb_state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-source and transmitter handshake bundle for the UART transmit arbiter.
// The master modport is the arbiter side; the slave modport is the FIFOs and transmitter.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 2
);
  import uart_tx_arbiter_pkg::*;

  logic [N_REQ-1:0]       req_valid;
  logic [ByteW*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]       req_last;
  logic [N_REQ-1:0]       req_pop;
  logic [ByteW-1:0]       tx_data;
  logic                   tx_send;
  logic                   tx_busy;

  modport master (
    input  req_valid, req_data, req_last, tx_busy,
    output req_pop, tx_data, tx_send
  );

  modport slave (
    output req_valid, req_data, req_last, tx_busy,
    input  req_pop, tx_data, tx_send
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
// Returns the winner as one-hot and as an index, plus a found flag.
module uart_tx_arbiter_rr_picker
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned IdxW = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IdxW-1:0]  ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IdxW-1:0]  idx,
  output logic             found
);

  always_comb begin
    int unsigned j;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    j      = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      j = (32'(ptr) + off) % N_REQ;
      if (!found && valid[j]) begin
        found     = 1'b1;
        onehot[j] = 1'b1;
        idx       = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ show-ahead byte FIFOs, round-robin,
// with optional packet lock that keeps the grant until a byte flagged last has gone out.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ        = 2,
  parameter bit          LOCK_PKT     = 1'b1,
  parameter int unsigned BUSY_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  uart_tx_arbiter_if.master        bus,
  output logic [N_REQ-1:0]         grant,
  output logic                     arb_busy,
  output logic                     err_timeout,
  output logic [15:0]              bytes_sent
);

  localparam int unsigned    IdxW    = idx_width(N_REQ);
  localparam int unsigned    TmrW    = $clog2(BUSY_TIMEOUT) + 1;
  localparam logic [TmrW-1:0] TmrLast = TmrW'(BUSY_TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [IdxW-1:0]  rr_q, rr_d;
  logic [ByteW-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic [15:0]      cnt_q, cnt_d;

  logic [N_REQ-1:0] pick_onehot;
  logic [IdxW-1:0]  pick_idx;
  logic             pick_found;
  logic [IdxW-1:0]  idx_next;
  logic             timeout_hit;

  uart_tx_arbiter_rr_picker #(
    .N_REQ (N_REQ)
  ) u_rr_picker (
    .valid  (bus.req_valid),
    .ptr    (rr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  assign idx_next    = (idx_q == IdxW'(N_REQ - 1)) ? '0 : idx_q + IdxW'(1);
  assign timeout_hit = (state_q == StWaitBusy) && !bus.tx_busy && (tmr_q == TmrLast);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    data_d  = data_q;
    last_d  = last_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (enable && pick_found && !bus.tx_busy) begin
          grant_d = pick_onehot;
          idx_d   = pick_idx;
          data_d  = bus.req_data[ByteW*pick_idx +: ByteW];
          last_d  = bus.req_last[pick_idx];
          state_d = StSend;
        end
      end
      StSend: begin
        tmr_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (bus.tx_busy) begin
          state_d = StWaitDone;
        end else if (timeout_hit) begin
          // Byte is lost; move on so a dead transmitter cannot pin one requester.
          grant_d = '0;
          rr_d    = idx_next;
          state_d = StIdle;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      StWaitDone: begin
        if (!bus.tx_busy) begin
          cnt_d = cnt_q + 16'd1;
          if (LOCK_PKT && !last_q && enable) begin
            if (bus.req_valid[idx_q]) begin
              data_d  = bus.req_data[ByteW*idx_q +: ByteW];
              last_d  = bus.req_last[idx_q];
              state_d = StSend;
            end else begin
              state_d = StHold;
            end
          end else begin
            grant_d = '0;
            rr_d    = idx_next;
            state_d = StIdle;
          end
        end
      end
      StHold: begin
        // Other requesters starve here on purpose: packets stay atomic on the line.
        if (!enable) begin
          grant_d = '0;
          state_d = StIdle;
        end else if (bus.req_valid[idx_q]) begin
          data_d  = bus.req_data[ByteW*idx_q +: ByteW];
          last_d  = bus.req_last[idx_q];
          state_d = StSend;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      idx_q   <= '0;
      rr_q    <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      tmr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.tx_send = (state_q == StSend);
  assign bus.req_pop = (state_q == StSend) ? grant_q : '0;
  assign bus.tx_data = data_q;
  assign grant       = grant_q;
  assign arb_busy    = (state_q != StIdle);
  assign err_timeout = timeout_hit;
  assign bytes_sent  = cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: FIFO and transmitter models, directed scenarios,
// then random packet rounds checked against a packet-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int unsigned N_REQ = 3;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } src_t;

  typedef struct {
    int         idx;
    logic [7:0] data;
    int         cyc;
  } rec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [N_REQ-1:0] grant;
  logic             arb_busy;
  logic             err_timeout;
  logic [15:0]      bytes_sent;

  uart_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

  uart_tx_arbiter #(
    .N_REQ        (N_REQ),
    .LOCK_PKT     (1'b1),
    .BUSY_TIMEOUT (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .bus         (bus),
    .grant       (grant),
    .arb_busy    (arb_busy),
    .err_timeout (err_timeout),
    .bytes_sent  (bytes_sent)
  );

  always #5 clk = ~clk;

  src_t             src_q [N_REQ][$];
  src_t             m_q   [N_REQ][$];
  rec_t             sent_q[$];
  rec_t             exp_q [$];
  logic [N_REQ-1:0] pend_pop;
  int               cyc, n_checks, n_errors;
  int               tx_dly, tx_hold, rr_m, cnt_m;
  bit               no_busy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N_REQ; i++) begin
      if (src_q[i].size() > 0) begin
        bus.req_valid[i]       = 1'b1;
        bus.req_data[8*i +: 8] = src_q[i][0].data;
        bus.req_last[i]        = src_q[i][0].last;
      end else begin
        bus.req_valid[i]       = 1'b0;
        bus.req_data[8*i +: 8] = 8'h00;
        bus.req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic push(input int idx, input logic [7:0] d, input logic l);
    src_q[idx].push_back('{data: d, last: l});
    drive();
  endtask

  function automatic bit src_any();
    for (int i = 0; i < N_REQ; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: FIFO pops and transmitter update just after the edge, then sample.
  task automatic tick();
    int k;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N_REQ; i++) if (pend_pop[i] && src_q[i].size() > 0) src_q[i].delete(0);
    pend_pop = '0;
    if (bus.tx_busy) begin
      tx_hold--;
      if (tx_hold == 0) bus.tx_busy = 1'b0;
    end else if (tx_dly > 0) begin
      tx_dly--;
      if (tx_dly == 0) begin
        bus.tx_busy = 1'b1;
        tx_hold     = 20;
      end
    end
    drive();
    #1;
    if (bus.tx_send) begin
      k = 0;
      for (int i = N_REQ - 1; i >= 0; i--) if (grant[i]) k = i;
      check_eq("grant_onehot", 32'($onehot(grant)), 1);
      check_eq("pop_grant", 32'(bus.req_pop), 32'(grant));
      check_eq("send_busy", 32'(bus.tx_busy), 0);
      check_eq("pop_nonempty", 32'(src_q[k].size() > 0), 1);
      if (src_q[k].size() > 0) check_eq("tx_head", 32'(bus.tx_data), 32'(src_q[k][0].data));
      sent_q.push_back('{idx: k, data: bus.tx_data, cyc: cyc});
      pend_pop = bus.req_pop;
      if (!no_busy) tx_dly = 2;
    end else if (bus.req_pop != '0) begin
      check_eq("stray_pop", 32'(bus.req_pop), 0);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((arb_busy || src_any()) && n < budget) begin
      tick();
      n++;
    end
    check_eq("wait_idle", {30'd0, arb_busy, src_any()}, 0);
  endtask

  task automatic wait_sends(input int want, input int budget);
    int n = 0;
    while (sent_q.size() < want && n < budget) begin
      tick();
      n++;
    end
    check_eq("wait_sends", 32'(sent_q.size() >= want), 1);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    tick();
    tick();
    rst_n  = 1'b1;
  endtask

  task automatic check_order(input string tag, input int idx[], input logic [7:0] dat[]);
    check_eq({tag, "_n"}, sent_q.size(), idx.size());
    for (int i = 0; i < idx.size() && i < sent_q.size(); i++) begin
      check_eq({tag, "_idx"}, sent_q[i].idx, idx[i]);
      check_eq({tag, "_dat"}, 32'(sent_q[i].data), 32'(dat[i]));
    end
  endtask

  // Packet-level model: serve whole packets, first non-empty requester from rr, then rr = k+1.
  task automatic random_round();
    src_t e;
    int   k;
    for (int i = 0; i < N_REQ; i++) begin
      m_q[i].delete();
      for (int p = 0; p < int'($urandom_range(0, 2)); p++) begin
        int len = int'($urandom_range(1, 3));
        for (int b = 0; b < len; b++) begin
          e = '{data: 8'($urandom), last: (b == len - 1)};
          src_q[i].push_back(e);
          m_q[i].push_back(e);
        end
      end
    end
    drive();
    exp_q.delete();
    sent_q.delete();
    forever begin
      k = -1;
      for (int o = 0; o < N_REQ; o++) begin
        int j = (rr_m + o) % N_REQ;
        if (k < 0 && m_q[j].size() > 0) k = j;
      end
      if (k < 0) break;
      do begin
        e = m_q[k].pop_front();
        exp_q.push_back('{idx: k, data: e.data, cyc: 0});
      end while (!e.last && m_q[k].size() > 0);
      rr_m = (k + 1) % N_REQ;
    end
    wait_idle(1500);
    cnt_m += exp_q.size();
    check_eq("rnd_n", sent_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
      check_eq("rnd_idx", sent_q[i].idx, exp_q[i].idx);
      check_eq("rnd_dat", 32'(sent_q[i].data), 32'(exp_q[i].data));
    end
    check_eq("rnd_count", 32'(bytes_sent), 32'(cnt_m[15:0]));
  endtask

  initial begin
    int   t0;
    int   cnt0;
    int   n;
    cyc = 0; n_checks = 0; n_errors = 0;
    tx_dly = 0; tx_hold = 0; no_busy = 1'b0;
    pend_pop = '0;
    bus.tx_busy = 1'b0;
    drive();
    do_reset();
    check_eq("rst_grant", 32'(grant), 0);
    check_eq("rst_busy", 32'(arb_busy), 0);
    check_eq("rst_send", 32'(bus.tx_send), 0);
    check_eq("rst_pop", 32'(bus.req_pop), 0);
    check_eq("rst_data", 32'(bus.tx_data), 0);
    check_eq("rst_count", 32'(bytes_sent), 0);
    check_eq("rst_err", 32'(err_timeout), 0);

    // Single byte
    enable = 1'b1;
    push(0, 8'h41, 1'b1);
    tick();
    check_eq("t1_send", 32'(bus.tx_send), 1);
    check_eq("t1_data", 32'(bus.tx_data), 32'h41);
    check_eq("t1_pop", 32'(bus.req_pop), 1);
    tick();
    check_eq("t1_pop_once", 32'(bus.req_pop), 0);
    run_cycles(10);
    check_eq("t1_grant_held", 32'(grant), 1);
    wait_idle(100);
    check_eq("t1_count", 32'(bytes_sent), 1);
    check_eq("t1_grant_rel", 32'(grant), 0);

    // Fairness with one-byte packets
    do_reset();
    enable = 1'b1;
    sent_q.delete();
    for (int i = 0; i < 4; i++) begin
      push(0, 8'hA0 + 8'(i), 1'b1);
      push(1, 8'hB0 + 8'(i), 1'b1);
    end
    wait_idle(400);
    check_order("t2", '{0, 1, 0, 1, 0, 1, 0, 1},
                '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hA3, 8'hB3});
    check_eq("t2_count", 32'(bytes_sent), 8);

    // Packet lock: three bytes back to back, then requester 1
    sent_q.delete();
    push(0, 8'hC0, 1'b0);
    push(0, 8'hC1, 1'b0);
    push(0, 8'hC2, 1'b1);
    push(1, 8'hD0, 1'b1);
    wait_idle(300);
    check_order("t3", '{0, 0, 0, 1}, '{8'hC0, 8'hC1, 8'hC2, 8'hD0});
    if (sent_q.size() == 4) begin
      check_eq("t3_locked_gap", sent_q[1].cyc - sent_q[0].cyc, 23);
      check_eq("t3_rearb_gap", sent_q[3].cyc - sent_q[2].cyc, 24);
    end

    // Packet lock with source running dry: HOLD starves requester 1
    sent_q.delete();
    push(0, 8'hE0, 1'b0);
    push(1, 8'hF0, 1'b1);
    tick();
    run_cycles(40);
    check_eq("t3_hold_grant", 32'(grant), 1);
    check_eq("t3_hold_busy", 32'(arb_busy), 1);
    check_eq("t3_hold_starve", sent_q.size(), 1);
    push(0, 8'hE1, 1'b1);
    wait_idle(300);
    check_order("t3h", '{0, 0, 1}, '{8'hE0, 8'hE1, 8'hF0});

    // Transmitter never goes busy
    cnt0 = int'(bytes_sent);
    no_busy = 1'b1;
    sent_q.delete();
    push(2, 8'h5A, 1'b1);
    wait_sends(1, 10);
    t0 = (sent_q.size() > 0) ? sent_q[0].cyc : cyc;
    n = 0;
    while (!err_timeout && n < 100) begin
      tick();
      n++;
    end
    check_eq("t4_delay", cyc - t0, 64);
    tick();
    check_eq("t4_pulse", 32'(err_timeout), 0);
    check_eq("t4_grant", 32'(grant), 0);
    check_eq("t4_count", 32'(bytes_sent), 32'(cnt0));
    no_busy = 1'b0;
    sent_q.delete();
    push(0, 8'h66, 1'b1);
    wait_idle(100);
    check_order("t4n", '{0}, '{8'h66});
    check_eq("t4_count_next", 32'(bytes_sent), 32'(cnt0 + 1));

    // Reset in the middle of a frame
    push(1, 8'h77, 1'b1);
    tick();
    run_cycles(5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("t5_grant", 32'(grant), 0);
    check_eq("t5_busy", 32'(arb_busy), 0);
    check_eq("t5_send", 32'(bus.tx_send), 0);
    check_eq("t5_pop", 32'(bus.req_pop), 0);
    check_eq("t5_data", 32'(bus.tx_data), 0);
    check_eq("t5_count", 32'(bytes_sent), 0);
    run_cycles(20);
    // Disabled with data pending, then HOLD released by disable
    enable = 1'b0;
    sent_q.delete();
    push(0, 8'h88, 1'b1);
    push(0, 8'h99, 1'b0);
    run_cycles(10);
    check_eq("t5_no_send", sent_q.size(), 0);
    check_eq("t5_idle", 32'(arb_busy), 0);
    enable = 1'b1;
    wait_sends(2, 100);
    run_cycles(30);
    check_eq("t5_hold_grant", 32'(grant), 1);
    enable = 1'b0;
    run_cycles(2);
    check_eq("t5_rel_grant", 32'(grant), 0);
    check_eq("t5_rel_busy", 32'(arb_busy), 0);
    enable = 1'b1;

    // Counter wrap
    force dut.cnt_q = 16'hFFFE;
    tick();
    tick();
    release dut.cnt_q;
    tick();
    check_eq("t6_preload", 32'(bytes_sent), 32'hFFFE);
    push(2, 8'h10, 1'b1);
    wait_idle(100);
    check_eq("t6_ffff", 32'(bytes_sent), 32'hFFFF);
    push(2, 8'h11, 1'b1);
    wait_idle(100);
    check_eq("t6_wrap", 32'(bytes_sent), 0);

    // Random packet rounds
    do_reset();
    enable = 1'b1;
    rr_m   = 0;
    cnt_m  = 0;
    for (int r = 0; r < 10; r++) random_round();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
